// File: rtl/multi_button_conditioner.sv
// Multi-channel button conditioner: synchronizer, debounce, edge pulses and auto-repeat.
// repeat/event are SystemVerilog keywords, so those ports are named repeat_pulse/event_pulse.
module multi_button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 0,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic                  clock,
    input  logic                  rstsync,
    input  logic [CHANNELS-1:0]   button,
    input  logic [2*CHANNELS-1:0] edge_sel,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   rise,
    output logic [CHANNELS-1:0]   fall,
    output logic [CHANNELS-1:0]   repeat_pulse,
    output logic [CHANNELS-1:0]   event_pulse,
    output logic                  any_event
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] HOLD_LOAD   = RC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [RC_W-1:0] REPEAT_LOAD = RC_W'(REPEAT_CYCLES - 1);
    localparam bit              REPEAT_EN   = (HOLD_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_chain;
        logic                   sync;
        logic                   level_q;
        logic                   level_d;
        logic                   level_next;
        logic                   toggle;
        logic                   press;
        logic [DB_W-1:0]        db_cnt;
        rpt_state_t             state;
        rpt_state_t             state_next;
        logic [RC_W-1:0]        rpt_cnt;
        logic [RC_W-1:0]        rpt_cnt_next;
        logic                   rpt_q;
        logic                   rpt_next;
        logic                   rise_c;
        logic                   fall_c;
        logic                   edge_evt;

        assign sync       = sync_chain[SYNC_STAGES-1];
        assign toggle     = (sync != level_q) && (db_cnt == DB_LAST);
        assign level_next = level_q ^ toggle;
        // The repeat timer starts on the edge that accepts the press, not a cycle later.
        assign press      = toggle && sync;

        always_ff @(posedge clock or negedge rstsync) begin
            if (!rstsync) begin
                sync_chain <= '0;
                level_q    <= 1'b0;
                level_d    <= 1'b0;
                db_cnt     <= '0;
            end else begin
                // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
                // so the chain shifts one stage per clock regardless of statement order.
                sync_chain <= {sync_chain[SYNC_STAGES-2:0], button[i]};
                level_q    <= level_next;
                level_d    <= level_q;
                if (sync == level_q || toggle) db_cnt <= '0;
                else                           db_cnt <= db_cnt + DB_W'(1);
            end
        end

        always_ff @(posedge clock or negedge rstsync) begin
            if (!rstsync) begin
                state   <= IDLE;
                rpt_cnt <= '0;
                rpt_q   <= 1'b0;
            end else begin
                state   <= state_next;
                rpt_cnt <= rpt_cnt_next;
                rpt_q   <= rpt_next;
            end
        end

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path can
            // leave one unassigned and infer a latch.
            state_next   = state;
            rpt_cnt_next = rpt_cnt;
            rpt_next     = 1'b0;
            case (state)
                IDLE: begin
                    if (REPEAT_EN && press) begin
                        state_next   = HOLD;
                        rpt_cnt_next = HOLD_LOAD;
                    end
                end
                HOLD, REPEAT: begin
                    // Looking at level_next drops the repeat in the same edge that raises fall.
                    if (!level_next) begin
                        state_next   = IDLE;
                        rpt_cnt_next = '0;
                    end else if (rpt_cnt == '0) begin
                        state_next   = REPEAT;
                        rpt_cnt_next = REPEAT_LOAD;
                        rpt_next     = 1'b1;
                    end else begin
                        rpt_cnt_next = rpt_cnt - RC_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        assign rise_c = level_q & ~level_d;
        assign fall_c = ~level_q & level_d;

        always_comb begin
            edge_evt = 1'b0;
            case (edge_sel[2*i +: 2])
                2'b00:   edge_evt = rise_c;
                2'b01:   edge_evt = fall_c;
                2'b10:   edge_evt = rise_c | fall_c;
                default: edge_evt = 1'b0;
            endcase
        end

        assign level[i]        = level_q;
        assign rise[i]         = rise_c;
        assign fall[i]         = fall_c;
        assign repeat_pulse[i] = rpt_q;
        assign event_pulse[i]  = edge_evt | rpt_q;
    end

    assign any_event = |event_pulse;

endmodule

// File: tb/tb_multi_button_conditioner.sv
// Bench for multi_button_conditioner: directed scenarios with hand-derived timing masks,
// then randomized traffic against a cycle-numbered behavioural model.
module tb_multi_button_conditioner;

    localparam int CH = 2;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int R  = 3;

    logic              clock = 1'b0;
    logic              rstsync;
    logic [CH-1:0]     button;
    logic [2*CH-1:0]   edge_sel;
    logic [CH-1:0]     level, rise, fall, repeat_pulse, event_pulse;
    logic              any_event;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    multi_button_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clock(clock), .rstsync(rstsync), .button(button), .edge_sel(edge_sel),
        .level(level), .rise(rise), .fall(fall), .repeat_pulse(repeat_pulse),
        .event_pulse(event_pulse), .any_event(any_event)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: samples seen by the chain, consecutive-mismatch run length,
    // and the edge number at which the current press was accepted.
    bit m_pipe    [CH][S];
    bit m_level   [CH];
    bit m_level_d [CH];
    bit m_rep     [CH];
    int m_run     [CH];
    int m_press   [CH];

    logic [63:0] rise_mask, fall_mask, rep_mask, evt_mask, ch1_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = 0; k < S; k++) m_pipe[ch][k] = 1'b0;
            m_level[ch]   = 1'b0;
            m_level_d[ch] = 1'b0;
            m_rep[ch]     = 1'b0;
            m_run[ch]     = 0;
            m_press[ch]   = -1;
        end
    endtask

    task automatic model_step();
        bit old_l, new_l, s;
        cyc++;
        if (!rstsync) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < CH; ch++) begin
            old_l = m_level[ch];
            new_l = old_l;
            s     = m_pipe[ch][S-1];
            if (s != old_l) begin
                m_run[ch]++;
                if (m_run[ch] == D) begin
                    new_l     = !old_l;
                    m_run[ch] = 0;
                end
            end else begin
                m_run[ch] = 0;
            end
            if (new_l && !old_l) m_press[ch] = cyc;
            if (!new_l)          m_press[ch] = -1;
            m_rep[ch] = (H > 0) && new_l && (m_press[ch] >= 0) &&
                        (cyc >= m_press[ch] + H) && (((cyc - m_press[ch] - H) % R) == 0);
            m_level_d[ch] = old_l;
            m_level[ch]   = new_l;
            for (int k = S - 1; k > 0; k--) m_pipe[ch][k] = m_pipe[ch][k-1];
            m_pipe[ch][0] = button[ch];
        end
    endtask

    function automatic logic [63:0] model_out();
        logic [CH-1:0] l, r, f, p, e;
        for (int ch = 0; ch < CH; ch++) begin
            l[ch] = m_level[ch];
            r[ch] = m_level[ch] & ~m_level_d[ch];
            f[ch] = ~m_level[ch] & m_level_d[ch];
            p[ch] = m_rep[ch];
            case (edge_sel[2*ch +: 2])
                2'b00:   e[ch] = r[ch];
                2'b01:   e[ch] = f[ch];
                2'b10:   e[ch] = r[ch] | f[ch];
                default: e[ch] = 1'b0;
            endcase
            e[ch] = e[ch] | p[ch];
        end
        return 64'({l, r, f, p, e, |e});
    endfunction

    function automatic logic [63:0] dut_out();
        return 64'({level, rise, fall, repeat_pulse, event_pulse, any_event});
    endfunction

    // Mask bit c holds the state after edge c, edge 1 being the first to sample btn.
    task automatic run_cycles(input int n, input logic [CH-1:0] btn,
                              input logic [2*CH-1:0] sel, input bit release_rst);
        rise_mask = '0; fall_mask = '0; rep_mask = '0; evt_mask = '0; ch1_mask = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            if (release_rst && c == 0) rstsync = 1'b1;
            button   = btn;
            edge_sel = sel;
            #1;
            check("outputs", dut_out(), model_out());
            rise_mask[c] = rise[0];
            fall_mask[c] = fall[0];
            rep_mask[c]  = repeat_pulse[0];
            evt_mask[c]  = event_pulse[0];
            ch1_mask[c]  = level[1] | rise[1] | fall[1] | event_pulse[1];
            @(posedge clock);
            model_step();
        end
    endtask

    task automatic mid_cycle_reset();
        #2 rstsync = 1'b0;
        #1 check("async_rst", dut_out(), 64'd0);
        model_reset();
    endtask

    initial begin
        int remain [CH];
        int rst_hold;
        rstsync  = 1'b0;
        button   = '0;
        edge_sel = '0;
        model_reset();
        #1 check("reset", dut_out(), 64'd0);
        run_cycles(2, 2'b00, 4'b0000, 0);
        run_cycles(3, 2'b00, 4'b0000, 1);

        // Clean press held into auto-repeat, then release.
        run_cycles(26, 2'b01, 4'b0000, 0);
        check("press_rise", rise_mask, 64'd1 << 6);
        check("press_rep", rep_mask, (64'd1 << 14) | (64'd1 << 17) | (64'd1 << 20) | (64'd1 << 23));
        check("press_evt", evt_mask, rise_mask | rep_mask);
        run_cycles(12, 2'b00, 4'b0000, 0);
        check("release_rep", rep_mask, (64'd1 << 0) | (64'd1 << 3));
        check("release_fall", fall_mask, 64'd1 << 6);

        // Bounce shorter than the debounce window.
        run_cycles(3, 2'b01, 4'b0000, 0);
        run_cycles(12, 2'b00, 4'b0000, 0);
        check("bounce_evt", evt_mask | rise_mask | fall_mask, 64'd0);

        // Both-edge mode, then repeat-only mode.
        run_cycles(10, 2'b01, 4'b0010, 0);
        check("both_press", evt_mask, 64'd1 << 6);
        run_cycles(12, 2'b00, 4'b0010, 0);
        check("both_release", evt_mask, (64'd1 << 4) | (64'd1 << 6));
        run_cycles(20, 2'b01, 4'b0011, 0);
        check("none_press", evt_mask, (64'd1 << 14) | (64'd1 << 17));
        run_cycles(12, 2'b00, 4'b0011, 0);
        check("none_release", evt_mask, (64'd1 << 0) | (64'd1 << 3));

        // Simultaneous press, channel 1 only glitches for two cycles.
        run_cycles(2, 2'b11, 4'b0000, 0);
        check("conc_ch1_a", ch1_mask, 64'd0);
        run_cycles(12, 2'b01, 4'b0000, 0);
        check("conc_ch1_b", ch1_mask, 64'd0);
        check("conc_ch0", rise_mask, 64'd1 << 4);
        run_cycles(12, 2'b00, 4'b0000, 0);

        // Reset in the middle of REPEAT with the button still held.
        run_cycles(20, 2'b01, 4'b0000, 0);
        mid_cycle_reset();
        run_cycles(2, 2'b01, 4'b0000, 0);
        check("rst_quiet", evt_mask | rise_mask | rep_mask, 64'd0);
        run_cycles(12, 2'b01, 4'b0000, 1);
        check("rst_rise", rise_mask, 64'd1 << 6);
        run_cycles(12, 2'b00, 4'b0000, 0);

        // Randomized traffic: mixes glitches, short presses and long holds.
        for (int ch = 0; ch < CH; ch++) remain[ch] = 0;
        rst_hold = 0;
        for (int it = 0; it < 2500; it++) begin
            @(negedge clock);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rstsync = 1'b1;
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (remain[ch] == 0) begin
                    button[ch] = ~button[ch];
                    remain[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                             : int'($urandom_range(1, D + H + 3*R + 4));
                end else begin
                    remain[ch]--;
                end
            end
            if ($urandom_range(0, 7) == 0) edge_sel = 4'($urandom);
            #1;
            check("random", dut_out(), model_out());
            @(posedge clock);
            model_step();
            if (rst_hold == 0 && $urandom_range(0, 199) == 0) begin
                mid_cycle_reset();
                rst_hold = $urandom_range(1, 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_button_conditioner.md
MULTI_BUTTON_CONDITIONER -- requirements
Module: multi_button_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent button channels, minimum 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change, minimum 1.
REQ-004 SHALL have parameter HOLD_CYCLES, default 0: cycles held before the first auto-repeat; 0 disables auto-repeat.
REQ-005 SHALL have parameter REPEAT_CYCLES, default 8: auto-repeat period, minimum 1.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all flops on posedge.
REQ-007 SHALL have port rstsync, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port button, input, CHANNELS bits: raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port edge_sel, input, 2*CHANNELS bits: per-channel event mode, bits [2i+1:2i] for channel i; 00 rise, 01 fall, 10 both, 11 no edge events.
REQ-010 SHALL have port level, output, CHANNELS bits: debounced level.
REQ-011 SHALL have port rise, output, CHANNELS bits: one-cycle pulse on each debounced 0->1.
REQ-012 SHALL have port fall, output, CHANNELS bits: one-cycle pulse on each debounced 1->0.
REQ-013 SHALL have port repeat, output, CHANNELS bits: one-cycle auto-repeat pulse.
REQ-014 SHALL have port event, output, CHANNELS bits: the edge pulse selected by edge_sel, ORed with repeat.
REQ-015 SHALL have port any_event, output, 1 bit: OR-reduction of event.

Function
REQ-016 Each channel SHALL pass button[i] through a SYNC_STAGES-deep flop chain; only the last stage (sync[i]) SHALL be used downstream.
REQ-017 Per channel, while sync[i] != level[i], a debounce counter SHALL increment each cycle; when sync[i] == level[i], the counter SHALL clear to 0 in that cycle.
REQ-018 At the edge where sync[i] != level[i] and the counter equals DEBOUNCE_CYCLES-1, level[i] SHALL toggle and the counter SHALL clear.
REQ-019 Latency: if button[i] changes and is first sampled at edge 1 and then held, level[i] SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-020 rise[i] SHALL be level[i] AND NOT level_d[i], where level_d[i] is level[i] delayed one flop; fall[i] SHALL be the complement form; each pulse SHALL be exactly one cycle wide.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES cycles at sync[i] SHALL produce no level change and no pulse.
REQ-022 Per channel, the repeat FSM SHALL have states IDLE, HOLD and REPEAT, with a shared down-counter sized by $clog2 of max(HOLD_CYCLES, REPEAT_CYCLES)+1.
REQ-023 The FSM SHALL go IDLE->HOLD on rise[i] when HOLD_CYCLES>0, loading the counter with HOLD_CYCLES-1.
REQ-024 In HOLD or REPEAT, the FSM SHALL decrement the counter each cycle.
REQ-025 At counter 0, the FSM SHALL register repeat[i]=1 for the next cycle, reload the counter with REPEAT_CYCLES-1, and enter or stay in REPEAT.
REQ-026 Consequence of REQ-023 to REQ-025: the first repeat[i] SHALL be high in the cycle after edge (rise edge + HOLD_CYCLES), and each later repeat SHALL follow every REPEAT_CYCLES cycles.
REQ-027 level[i]==0 in HOLD or REPEAT SHALL force IDLE at the next edge; no repeat[i] SHALL assert in or after the cycle fall[i] is high.
REQ-028 With HOLD_CYCLES==0, the FSM SHALL stay in IDLE and repeat SHALL be constant 0.
REQ-029 edge_sel SHALL be sampled combinationally; a change of edge_sel SHALL affect event from the same cycle, and SHALL never affect level, rise, fall or repeat.
REQ-030 Channels SHALL be fully independent; simultaneous activity on any set of channels SHALL produce the per-channel behaviour unchanged.

Reset
REQ-031 While rstsync==0, all flops SHALL clear asynchronously, without a clock edge: sync chain, counters, level, level_d, repeat register; FSM to IDLE.
REQ-032 While rstsync==0, every output (level, rise, fall, repeat, event, any_event) SHALL be 0.
REQ-033 A button already high at reset release SHALL be treated as a new press: level rises after the REQ-019 latency and rise pulses once.
REQ-034 Reset asserted mid-debounce or mid-repeat SHALL abort that activity with no residual pulse after release.

Verification (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-035 Clean press: button[0] 0->1 sampled at edge 1 and held -> level[0]=1 from edge 6; rise[0]=1 only between edges 6 and 7; with edge_sel[1:0]=00, event[0] and any_event match rise[0].
REQ-036 Bounce: button[0] high for 3 cycles, then low -> level, rise, fall and event stay 0 throughout.
REQ-037 Hold: held press from REQ-035 -> repeat[0] high in the cycles after edges 14, 17 and 20; release -> fall[0] pulses and no further repeat.
REQ-038 Modes: edge_sel[1:0]=10 gives an event[0] pulse on both press and release; edge_sel[1:0]=11 gives event[0] only on repeat pulses.
REQ-039 Async reset: rstsync dropped between edges during REPEAT -> all outputs 0 immediately; after release with button[0] still high -> rise[0] again at edge 6 after release.
REQ-040 Concurrency: both channels pressed on the same edge, channel 1 with a 2-cycle glitch -> channel 0 per REQ-035; channel 1 shows no pulses.
